// File: rtl/tsip_timing_decoder_pkg.sv
// Shared constants, FSM state encoding and payload field offsets for the
// TSIP Primary Timing decoder.
package tsip_pkg;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_DATA,
    S_DATA_DLE,
    S_SKIP,
    S_SKIP_DLE
  } state_t;

  // De-stuffed payload offsets; index 0 is the subcode.
  localparam logic [4:0] IDX_FLAG    = 5'd9;
  localparam logic [4:0] IDX_SEC     = 5'd10;
  localparam logic [4:0] IDX_MIN     = 5'd11;
  localparam logic [4:0] IDX_HOUR    = 5'd12;
  localparam logic [4:0] IDX_DAY     = 5'd13;
  localparam logic [4:0] IDX_MONTH   = 5'd14;
  localparam logic [4:0] IDX_YEAR_HI = 5'd15;
  localparam logic [4:0] IDX_YEAR_LO = 5'd16;

endpackage

// File: rtl/tsip_timing_decoder_if.sv
// Byte stream with a one-cycle valid, used for both the raw UART bytes and
// the de-stuffed payload bytes.
interface tsip_timing_decoder_if;
  logic [7:0] data;
  logic       dv;

  modport master (output data, output dv);
  modport slave  (input  data, input  dv);
endinterface

// File: rtl/tsip_timing_decoder_destuffer.sv
// TSIP framing: finds DLE-ID packet starts, strips DLE stuffing and flags
// DLE-ETX ends and broken DLE escapes inside accepted packets.
module tsip_destuffer
  import tsip_pkg::*;
#(
  parameter logic [7:0] P_PKT_ID = 8'h8F
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  tsip_timing_decoder_if.slave        i_rx,
  tsip_timing_decoder_if.master       o_ds,
  input  logic                        i_skip,
  output logic                        o_sop,
  output logic                        o_eop,
  output logic                        o_frame_err
);

  state_t r_state;
  state_t w_next;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Outputs are decoded apart from next-state so that i_skip, which the top
  // derives from o_ds, never feeds back into this block.
  always_comb begin
    o_ds.data   = i_rx.data;
    o_ds.dv     = 1'b0;
    o_sop       = 1'b0;
    o_eop       = 1'b0;
    o_frame_err = 1'b0;
    if (i_rx.dv) begin
      case (r_state)
        S_ID:       o_sop = (i_rx.data == P_PKT_ID);
        S_DATA:     o_ds.dv = (i_rx.data != DLE);
        S_DATA_DLE: begin
          if (i_rx.data == DLE)      o_ds.dv = 1'b1;
          else if (i_rx.data == ETX) o_eop   = 1'b1;
          else begin
            o_frame_err = 1'b1;
            o_sop       = (i_rx.data == P_PKT_ID);
          end
        end
        S_SKIP_DLE: o_sop = (i_rx.data == P_PKT_ID);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_rx.dv) begin
      case (r_state)
        S_IDLE: if (i_rx.data == DLE) w_next = S_ID;
        S_ID: begin
          if (i_rx.data == P_PKT_ID)                         w_next = S_DATA;
          else if ((i_rx.data == DLE) || (i_rx.data == ETX)) w_next = S_IDLE;
          else                                               w_next = S_SKIP;
        end
        S_DATA: begin
          if (i_rx.data == DLE) w_next = S_DATA_DLE;
          else if (i_skip)      w_next = S_SKIP;
        end
        S_DATA_DLE: begin
          if (i_rx.data == DLE)           w_next = i_skip ? S_SKIP : S_DATA;
          else if (i_rx.data == ETX)      w_next = S_IDLE;
          else if (i_rx.data == P_PKT_ID) w_next = S_DATA;
          else                            w_next = S_SKIP;
        end
        S_SKIP: if (i_rx.data == DLE) w_next = S_SKIP_DLE;
        S_SKIP_DLE: begin
          if (i_rx.data == DLE)           w_next = S_SKIP;
          else if (i_rx.data == ETX)      w_next = S_IDLE;
          else if (i_rx.data == P_PKT_ID) w_next = S_DATA;
          else                            w_next = S_SKIP;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tsip_timing_decoder.sv
// Extracts UTC date/time from TSIP Primary Timing packets (0x8F-AB) and
// publishes it on the thunder_* bus with a one-cycle commit strobe.
module tsip_timing_decoder
  import tsip_pkg::*;
#(
  parameter logic [7:0]  P_PKT_ID      = 8'h8F,
  parameter logic [7:0]  P_SUBCODE     = 8'hAB,
  parameter int unsigned P_PAYLOAD_LEN = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_dv,
  output logic        o_thunder_packet_dv,
  output logic [15:0] o_thunder_year,
  output logic [7:0]  o_thunder_month,
  output logic [7:0]  o_thunder_day,
  output logic [7:0]  o_thunder_hour,
  output logic [7:0]  o_thunder_minutes,
  output logic [7:0]  o_thunder_seconds,
  output logic [7:0]  o_timing_flag,
  output logic        o_pkt_error
);

  localparam logic [4:0] LP_LEN = 5'(P_PAYLOAD_LEN);

  tsip_timing_decoder_if u_rx_if ();
  tsip_timing_decoder_if u_ds_if ();

  logic w_sop, w_eop, w_frame_err, w_skip, w_commit_ok;

  logic [4:0]  r_cnt;
  logic        r_ovf;
  logic [7:0]  r_sh_flag, r_sh_sec, r_sh_min, r_sh_hour, r_sh_day, r_sh_month;
  logic [7:0]  r_sh_year_hi, r_sh_year_lo;
  logic        r_dv, r_err;
  logic [15:0] r_year;
  logic [7:0]  r_month, r_day, r_hour, r_min, r_sec, r_flag;

  assign u_rx_if.data = i_rx_byte;
  assign u_rx_if.dv   = i_rx_dv;

  tsip_destuffer #(
    .P_PKT_ID (P_PKT_ID)
  ) u_destuffer (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (u_rx_if),
    .o_ds        (u_ds_if),
    .i_skip      (w_skip),
    .o_sop       (w_sop),
    .o_eop       (w_eop),
    .o_frame_err (w_frame_err)
  );

  // A wrong subcode sends the framer to skip mode before anything is stored.
  assign w_skip      = u_ds_if.dv && (r_cnt == '0) && (u_ds_if.data != P_SUBCODE);
  assign w_commit_ok = (r_cnt == LP_LEN) && !r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_sh_flag    <= '0;
      r_sh_sec     <= '0;
      r_sh_min     <= '0;
      r_sh_hour    <= '0;
      r_sh_day     <= '0;
      r_sh_month   <= '0;
      r_sh_year_hi <= '0;
      r_sh_year_lo <= '0;
      r_dv         <= 1'b0;
      r_err        <= 1'b0;
      r_year       <= '0;
      r_month      <= '0;
      r_day        <= '0;
      r_hour       <= '0;
      r_min        <= '0;
      r_sec        <= '0;
      r_flag       <= '0;
    end else begin
      r_dv  <= 1'b0;
      r_err <= 1'b0;
      if (w_sop) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (u_ds_if.dv) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 5'd1;
        if (r_cnt >= LP_LEN) begin
          r_ovf <= 1'b1;
        end else begin
          case (r_cnt)
            IDX_FLAG:    r_sh_flag    <= u_ds_if.data;
            IDX_SEC:     r_sh_sec     <= u_ds_if.data;
            IDX_MIN:     r_sh_min     <= u_ds_if.data;
            IDX_HOUR:    r_sh_hour    <= u_ds_if.data;
            IDX_DAY:     r_sh_day     <= u_ds_if.data;
            IDX_MONTH:   r_sh_month   <= u_ds_if.data;
            IDX_YEAR_HI: r_sh_year_hi <= u_ds_if.data;
            IDX_YEAR_LO: r_sh_year_lo <= u_ds_if.data;
            default: ;
          endcase
        end
      end
      if (w_eop) begin
        if (w_commit_ok) begin
          r_dv    <= 1'b1;
          r_flag  <= r_sh_flag;
          r_sec   <= r_sh_sec;
          r_min   <= r_sh_min;
          r_hour  <= r_sh_hour;
          r_day   <= r_sh_day;
          r_month <= r_sh_month;
          r_year  <= {r_sh_year_hi, r_sh_year_lo};
        end else begin
          r_err <= 1'b1;
        end
      end
      if (w_frame_err) r_err <= 1'b1;
    end
  end

  assign o_thunder_packet_dv = r_dv;
  assign o_pkt_error         = r_err;
  assign o_thunder_year      = r_year;
  assign o_thunder_month     = r_month;
  assign o_thunder_day       = r_day;
  assign o_thunder_hour      = r_hour;
  assign o_thunder_minutes   = r_min;
  assign o_thunder_seconds   = r_sec;
  assign o_timing_flag       = r_flag;

endmodule

// File: tb/tb_tsip_timing_decoder.sv
// Directed bench for tsip_timing_decoder: table of whole packets with
// hand-computed results, plus framing-error and mid-packet-reset sequences.
module tb_tsip_timing_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tsip_timing_decoder_if bus ();

  logic        o_dv, o_err;
  logic [15:0] o_year;
  logic [7:0]  o_month, o_day, o_hour, o_min, o_sec, o_flag;

  tsip_timing_decoder #(
    .P_PKT_ID      (8'h8F),
    .P_SUBCODE     (8'hAB),
    .P_PAYLOAD_LEN (17)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_rx_byte           (bus.data),
    .i_rx_dv             (bus.dv),
    .o_thunder_packet_dv (o_dv),
    .o_thunder_year      (o_year),
    .o_thunder_month     (o_month),
    .o_thunder_day       (o_day),
    .o_thunder_hour      (o_hour),
    .o_thunder_minutes   (o_min),
    .o_thunder_seconds   (o_sec),
    .o_timing_flag       (o_flag),
    .o_pkt_error         (o_err)
  );

  typedef struct {
    logic [7:0]  id;
    logic [7:0]  sub;
    logic [31:0] tow;
    logic [7:0]  flag, sec, min, hr, day, mon;
    logic [15:0] year;
    int          len;
    int          gap;
    logic        e_dv, e_err;
    logic [7:0]  e_flag, e_sec, e_min, e_hr, e_day, e_mon;
    logic [15:0] e_year;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] q_pl[$];

  int n_assert = 0;
  int n_fail   = 0;
  int n_dv = 0, n_err = 0, n_both = 0, n_long = 0;
  logic p_dv = 1'b0, p_err = 1'b0;

  always @(negedge clk) begin
    if (o_dv === 1'b1)  n_dv++;
    if (o_err === 1'b1) n_err++;
    if ((o_dv === 1'b1) && (o_err === 1'b1)) n_both++;
    if (((o_dv === 1'b1) && p_dv) || ((o_err === 1'b1) && p_err)) n_long++;
    p_dv  = (o_dv === 1'b1);
    p_err = (o_err === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk); #2;
      bus.dv   = 1'b0;
      bus.data = 8'h10;
    end
    @(posedge clk); #2;
    bus.data = b;
    bus.dv   = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      bus.dv   = 1'b0;
      bus.data = 8'h00;
    end
  endtask

  task automatic mk_pl(input logic [7:0] sub, input logic [31:0] tow, input logic [7:0] flag,
                       input logic [7:0] sec, input logic [7:0] min, input logic [7:0] hr,
                       input logic [7:0] day, input logic [7:0] mon, input logic [15:0] year,
                       input int len);
    q_pl = {sub, tow[31:24], tow[23:16], tow[15:8], tow[7:0], 8'h08, 8'h4E, 8'h00, 8'h12,
            flag, sec, min, hr, day, mon, year[15:8], year[7:0]};
    while (q_pl.size() > len) void'(q_pl.pop_back());
    while (q_pl.size() < len) q_pl.push_back(8'h55);
  endtask

  task automatic send_body(input int from, input int gap);
    for (int i = from; i < q_pl.size(); i++) begin
      send_byte(q_pl[i], gap);
      if (q_pl[i] == 8'h10) send_byte(8'h10, gap);
    end
    send_byte(8'h10, gap);
    send_byte(8'h03, gap);
  endtask

  task automatic chk_time(input string p, input logic [7:0] f, input logic [7:0] s,
                          input logic [7:0] mi, input logic [7:0] h, input logic [7:0] d,
                          input logic [7:0] mo, input logic [15:0] y);
    chk({p, ".flag"},  o_flag,  f);
    chk({p, ".sec"},   o_sec,   s);
    chk({p, ".min"},   o_min,   mi);
    chk({p, ".hour"},  o_hour,  h);
    chk({p, ".day"},   o_day,   d);
    chk({p, ".month"}, o_month, mo);
    chk({p, ".year"},  o_year,  y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_dv, b_err;
    string p;

    //          id     sub    tow           flag   sec    min    hr     day    mon    year     len gap  dv    err   e_flag e_sec  e_min  e_hr   e_day  e_mon  e_year
    vecs[0] = '{8'h8F, 8'hAB, 32'h0001_2345, 8'h03, 8'd28, 8'd55, 8'd11, 8'd15, 8'd7,  16'd2020, 17, 0, 1'b1, 1'b0, 8'h03, 8'd28, 8'd55, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[1] = '{8'h8F, 8'hAB, 32'h0010_2030, 8'h03, 8'd30, 8'd16, 8'd11, 8'd15, 8'd7,  16'd2020, 17, 2, 1'b1, 1'b0, 8'h03, 8'd30, 8'd16, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[2] = '{8'h8F, 8'hAC, 32'h0000_0001, 8'h00, 8'd5,  8'd1,  8'd2,  8'd3,  8'd4,  16'd1999, 17, 0, 1'b0, 1'b0, 8'h03, 8'd30, 8'd16, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[3] = '{8'h47, 8'hAB, 32'h1010_1010, 8'h00, 8'd6,  8'd1,  8'd2,  8'd3,  8'd4,  16'd1999, 17, 0, 1'b0, 1'b0, 8'h03, 8'd30, 8'd16, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[4] = '{8'h8F, 8'hAB, 32'h0000_0002, 8'h03, 8'd29, 8'd55, 8'd11, 8'd15, 8'd7,  16'd2020, 17, 0, 1'b1, 1'b0, 8'h03, 8'd29, 8'd55, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[5] = '{8'h8F, 8'hAB, 32'h0000_0003, 8'h03, 8'd44, 8'd44, 8'd12, 8'd16, 8'd8,  16'd2021, 16, 0, 1'b0, 1'b1, 8'h03, 8'd29, 8'd55, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[6] = '{8'h8F, 8'hAB, 32'h0000_0004, 8'h03, 8'd45, 8'd45, 8'd12, 8'd16, 8'd8,  16'd2021, 18, 1, 1'b0, 1'b1, 8'h03, 8'd29, 8'd55, 8'd11, 8'd15, 8'd7,  16'h07E4};
    vecs[7] = '{8'h8F, 8'hAB, 32'h0000_0005, 8'h10, 8'd59, 8'd59, 8'd23, 8'd31, 8'd12, 16'h0810, 17, 0, 1'b1, 1'b0, 8'h10, 8'd59, 8'd59, 8'd23, 8'd31, 8'd12, 16'h0810};

    rst      = 1'b1;
    bus.dv   = 1'b0;
    bus.data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.dv",  o_dv,  1'b0);
    chk("reset.err", o_err, 1'b0);
    chk_time("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    @(posedge clk); #2;
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      p = $sformatf("v%0d", v);
      idle(2);
      b_dv  = n_dv;
      b_err = n_err;
      mk_pl(vecs[v].sub, vecs[v].tow, vecs[v].flag, vecs[v].sec, vecs[v].min, vecs[v].hr,
            vecs[v].day, vecs[v].mon, vecs[v].year, vecs[v].len);
      send_byte(8'h10, vecs[v].gap);
      send_byte(vecs[v].id, vecs[v].gap);
      send_body(0, vecs[v].gap);
      idle(1);
      @(negedge clk);
      chk({p, ".dv_at_etx+1"},  o_dv,  vecs[v].e_dv);
      chk({p, ".err_at_etx+1"}, o_err, vecs[v].e_err);
      chk_time(p, vecs[v].e_flag, vecs[v].e_sec, vecs[v].e_min, vecs[v].e_hr,
               vecs[v].e_day, vecs[v].e_mon, vecs[v].e_year);
      idle(3);
      chk({p, ".dv_pulses"},  n_dv - b_dv,   int'(vecs[v].e_dv));
      chk({p, ".err_pulses"}, n_err - b_err, int'(vecs[v].e_err));
    end

    // DLE followed by 0x8F mid-payload: error, then that 0x8F opens a new packet.
    idle(2);
    b_dv  = n_dv;
    b_err = n_err;
    send_byte(8'h10, 0);
    send_byte(8'h8F, 0);
    send_byte(8'hAB, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    send_byte(8'h03, 0);
    send_byte(8'h10, 0);
    send_byte(8'h8F, 0);
    mk_pl(8'hAB, 32'h0000_0006, 8'h01, 8'd40, 8'd41, 8'd5, 8'd2, 8'd3, 16'd2021, 17);
    send_byte(q_pl[0], 0);
    @(negedge clk);
    chk("frame.err_pulse", o_err, 1'b1);
    send_body(1, 0);
    idle(1);
    @(negedge clk);
    chk("frame.dv",  o_dv,  1'b1);
    chk("frame.err", o_err, 1'b0);
    chk_time("frame", 8'h01, 8'd40, 8'd41, 8'd5, 8'd2, 8'd3, 16'h07E5);
    idle(3);
    chk("frame.dv_pulses",  n_dv - b_dv,   1);
    chk("frame.err_pulses", n_err - b_err, 1);

    // Reset after payload byte 8 of a packet, then a complete packet.
    idle(2);
    b_dv  = n_dv;
    b_err = n_err;
    mk_pl(8'hAB, 32'h0000_0007, 8'h00, 8'd50, 8'd50, 8'd9, 8'd9, 8'd9, 16'd2022, 17);
    send_byte(8'h10, 0);
    send_byte(8'h8F, 0);
    for (int i = 0; i < 9; i++) send_byte(q_pl[i], 0);
    @(posedge clk); #2;
    bus.dv = 1'b0;
    rst    = 1'b1;
    @(posedge clk); #2;
    @(negedge clk);
    chk("midrst.dv",  o_dv,  1'b0);
    chk("midrst.err", o_err, 1'b0);
    chk_time("midrst", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0000);
    @(posedge clk); #2;
    rst = 1'b0;
    mk_pl(8'hAB, 32'h0000_0008, 8'h00, 8'd31, 8'd0, 8'd0, 8'd1, 8'd1, 16'd2021, 17);
    send_byte(8'h10, 0);
    send_byte(8'h8F, 0);
    send_body(0, 0);
    idle(1);
    @(negedge clk);
    chk("postrst.dv", o_dv, 1'b1);
    chk_time("postrst", 8'h00, 8'd31, 8'd0, 8'd0, 8'd1, 8'd1, 16'h07E5);
    idle(3);
    chk("postrst.dv_pulses",  n_dv - b_dv,   1);
    chk("postrst.err_pulses", n_err - b_err, 0);

    chk("strobe_overlap", n_both, 0);
    chk("strobe_stretch", n_long, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tsip_timing_decoder.md
Name: tsip_timing_decoder

Overview:
- Receives the Trimble Thunderbolt TSIP byte stream from the UART receiver.
- Removes DLE byte-stuffing and frames packets.
- Extracts the UTC date/time from the Primary Timing packet (ID 0x8F, subcode 0xAB).
- Drives the thunder_* time bus and the one-cycle packet data-valid flag consumed by pulse_generator, which compares that time against the user's scheduled pulse time.

Parameters:
- P_PKT_ID, 8'h8F, TSIP super-packet ID to accept.
- P_SUBCODE, 8'hAB, required first payload byte (Primary Timing).
- P_PAYLOAD_LEN, 17, de-stuffed payload bytes between ID and DLE-ETX, subcode included.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rx_byte  in  8  byte from UART receiver.
- i_rx_dv  in  1  i_rx_byte valid, one cycle per byte.
- o_thunder_packet_dv  out  1  one-cycle strobe: new time committed.
- o_thunder_year  out  16  four-digit year.
- o_thunder_month  out  8  month, 1-12.
- o_thunder_day  out  8  day, 1-31.
- o_thunder_hour  out  8  hour, 0-23.
- o_thunder_minutes  out  8  minutes, 0-59.
- o_thunder_seconds  out  8  seconds, 0-59.
- o_timing_flag  out  8  TSIP timing flag byte (bit0 = UTC/GPS).
- o_pkt_error  out  1  one-cycle strobe: malformed 0x8F-AB packet.

Behaviour:
- Reset (synchronous, active-high, applied at i_clk edge while i_rst=1):
  - All outputs = 0; FSM returns to S_IDLE; byte counter and shadow registers cleared.
  - A reset mid-packet discards the partial packet with no dv and no error.
- Bytes are processed only in cycles with i_rx_dv=1; the FSM holds otherwise. DLE=8'h10, ETX=8'h03.
- FSM states and transitions:
  - S_IDLE: DLE -> S_ID; any other byte ignored.
  - S_ID:
    - byte==P_PKT_ID -> S_DATA, cnt=0.
    - DLE or ETX -> S_IDLE.
    - any other byte -> S_SKIP.
  - S_DATA:
    - DLE -> S_DATA_DLE.
    - otherwise store the byte at index cnt, then cnt++.
  - S_DATA_DLE:
    - DLE -> store literal 8'h10, cnt++, -> S_DATA.
    - ETX -> end of packet: commit check, -> S_IDLE.
    - any other byte -> framing error: o_pkt_error=1, byte treated as a new packet ID (P_PKT_ID -> S_DATA with cnt=0, else S_SKIP).
  - S_SKIP (foreign packet): DLE -> S_SKIP_DLE.
  - S_SKIP_DLE:
    - DLE -> S_SKIP.
    - ETX -> S_IDLE.
    - any other byte -> new packet ID, same rule as S_ID.
- Subcode check: when the index-0 byte != P_SUBCODE -> S_SKIP silently, no error. Other 0x8F subcodes (e.g. 0xAC) are normal traffic.
- Overflow: when cnt reaches P_PAYLOAD_LEN, further data bytes are not stored; an overflow flag is set. cnt saturates at 31 (5 bits).
- Commit at ETX:
  - If cnt==P_PAYLOAD_LEN and no overflow: outputs load from the shadow registers and o_thunder_packet_dv=1 on the next clock edge. Latency is 1 cycle after the ETX byte's i_rx_dv cycle.
  - Otherwise: o_pkt_error=1 for one cycle, outputs hold.
- Payload index map (multi-byte fields are big-endian):
  - 0 subcode
  - 1-4 TOW (ignored)
  - 5-6 week (ignored)
  - 7-8 UTC offset (ignored)
  - 9 timing flag
  - 10 seconds
  - 11 minutes
  - 12 hours
  - 13 day
  - 14 month
  - 15 year MSB
  - 16 year LSB
- Output stability:
  - Time outputs change only on the commit cycle and are stable between strobes.
  - o_thunder_packet_dv and o_pkt_error are never asserted in the same cycle and never for more than one cycle.
- No range checking of field values; the time source is trusted.

Decomposition:
- Package tsip_pkg:
  - DLE and ETX constants.
  - FSM state enum: S_IDLE, S_ID, S_DATA, S_DATA_DLE, S_SKIP, S_SKIP_DLE.
  - Payload index constants: IDX_FLAG=9, IDX_SEC=10, IDX_MIN=11, IDX_HOUR=12, IDX_DAY=13, IDX_MONTH=14, IDX_YEAR_HI=15, IDX_YEAR_LO=16.
- Sub-module tsip_destuffer: framing and DLE removal only. Outputs de-stuffed byte + dv, plus start-of-packet and end-of-packet strobes. The field extractor and commit logic live in the top.

Test Plan:
- Nominal packet, 2020-07-15 11:55:28, flag 0x03 -> one cycle after ETX: dv=1, year=2020 (0x07E4), month=7, day=15, hour=11, minutes=55, seconds=28; o_pkt_error stays 0.
- Stuffing, minutes=16 sent as DLE DLE and a TOW byte 0x10 -> minutes=16, all other fields correct, dv pulses once.
- Foreign traffic: 0x8F-AC packet and an ID 0x47 packet whose payload contains DLE DLE, then a valid 0x8F-AB with seconds=29 -> dv only once, seconds=29, no error.
- Short packet (16 payload bytes) and long packet (18 payload bytes) -> o_pkt_error=1 for one cycle each; outputs keep the prior values; no dv.
- Framing error (DLE followed by 0x8F mid-payload), then a full payload -> one error pulse, then dv with the new time.
- Reset after byte 8 of a packet, then a full packet with seconds=31 -> outputs 0 during reset, no dv/error from the aborted packet, dv with seconds=31 afterwards.
